running_mean_window: RTL

- Upstream stage of the barrel left-shifter in the running-mean custom IP.
- Takes a stream of signed neural samples and keeps a sliding window of their absolute values.
- Outputs the window mean (32-bit, zero-extended) plus a registered shift amount. These drive the shifter's A and S inputs to form the spike threshold (mean << k).
- Valid/ready on both sides; one result per accepted sample.

---
 rtl/running_mean_window.sv | 125 ++++++++++++
 1 files changed

// File: rtl/running_mean_window.sv
// running_mean_window
// Sliding-window mean of |sample| feeding the threshold barrel shifter.
// Produces one registered (mean, shift) result per accepted sample behind a
// single output register with valid/ready on both sides.
// Optional build macro: MEAN_ROUND_EN (round-half-up output mean instead of
// truncation; the accumulator is identical in both builds).

module running_mean_window #(
    parameter int DATA_W   = 16,
    parameter int LOG2_WIN = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic signed [DATA_W-1:0] s_data,
    input  logic [4:0]               shift_k,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [31:0]              m_mean,
    output logic [4:0]               m_shift,
    output logic                     warm
);

    localparam int WIN   = 1 << LOG2_WIN;
    localparam int ACC_W = DATA_W + LOG2_WIN;
    localparam int ABS_W = DATA_W - 1;

    localparam logic [DATA_W-1:0]   MOST_NEG  = {1'b1, {ABS_W{1'b0}}};
    localparam logic [LOG2_WIN:0]   LAST_FILL = (LOG2_WIN + 1)'(WIN - 1);

    typedef enum logic {
        FILL,
        RUN
    } state_t;

    state_t              state;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_next;
    logic [LOG2_WIN-1:0] wr_ptr;
    logic [LOG2_WIN:0]   fill_cnt;
    logic [ABS_W-1:0]    win_buf [WIN];
    logic [ABS_W-1:0]    abs_val;
    logic [ABS_W-1:0]    oldest;
    logic [DATA_W-1:0]   neg_data;
    logic [31:0]         mean_next;
    logic                accept;

`ifdef MEAN_ROUND_EN
    localparam logic [ACC_W:0] HALF = (ACC_W + 1)'(1) << (LOG2_WIN - 1);
    logic [ACC_W:0] rnd_sum;
`endif

    // The single output register can take a new result whenever it is empty
    // or being drained this cycle, so back-pressure is purely combinational.
    assign s_ready = !m_valid || m_ready;
    assign accept  = s_valid && s_ready;

    // Absolute value of the incoming sample; the most negative code has no
    // positive twin in DATA_W-1 bits, so it saturates to the largest magnitude.
    always_comb begin
        neg_data = -s_data;
        abs_val  = '0;
        if (s_data == MOST_NEG) begin
            abs_val = '1;
        end else if (s_data[DATA_W-1]) begin
            abs_val = neg_data[ABS_W-1:0];
        end else begin
            abs_val = s_data[ABS_W-1:0];
        end
    end

    // Window update: subtract the sample falling out of the window (zero while
    // the window is still filling) and add the new one; compute the output mean.
    always_comb begin
        oldest   = (state == RUN) ? win_buf[wr_ptr] : '0;
        acc_next = acc + ACC_W'(abs_val) - ACC_W'(oldest);
`ifdef MEAN_ROUND_EN
        rnd_sum   = {1'b0, acc_next} + HALF;
        mean_next = 32'(rnd_sum >> LOG2_WIN);
`else
        mean_next = 32'(acc_next >> LOG2_WIN);
`endif
    end

    // Circular window storage; deliberately not cleared by reset since the
    // FILL state ignores its contents until every slot has been rewritten.
    always_ff @(posedge clk) begin
        if (accept) begin
            win_buf[wr_ptr] <= abs_val;
        end
    end

    // FILL/RUN control plus accumulator, pointer and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FILL;
            warm     <= 1'b0;
            fill_cnt <= '0;
            acc      <= '0;
            wr_ptr   <= '0;
            m_valid  <= 1'b0;
            m_mean   <= '0;
            m_shift  <= '0;
        end else begin
            if (accept) begin
                acc     <= acc_next;
                wr_ptr  <= wr_ptr + 1'b1;
                m_mean  <= mean_next;
                m_shift <= shift_k;
                m_valid <= 1'b1;
                if (state == FILL) begin
                    fill_cnt <= fill_cnt + 1'b1;
                    if (fill_cnt == LAST_FILL) begin
                        state <= RUN;
                        warm  <= 1'b1;
                    end
                end
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule
